// File: rtl/bias_fetch_scheduler_if.sv
// Bundles the loader write port, the single-port bias BRAM port and the bias stream to the PE array.
// The scheduler takes the master view; the environment (loader, BRAM, consumer) takes the slave view.
interface bias_fetch_scheduler_if #(
    parameter int DW = 32,
    parameter int AW = 9
);
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_grant;

    logic          bram_en;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata;
    logic [DW-1:0] bram_rdata;

    logic [DW-1:0] bias_out;
    logic [11:0]   bias_ch;
    logic          bias_valid;
    logic          bias_ready;

    modport master (
        input  wr_req, wr_addr, wr_data, bram_rdata, bias_ready,
        output wr_grant, bram_en, bram_we, bram_addr, bram_wdata,
               bias_out, bias_ch, bias_valid
    );

    modport slave (
        output wr_req, wr_addr, wr_data, bram_rdata, bias_ready,
        input  wr_grant, bram_en, bram_we, bram_addr, bram_wdata,
               bias_out, bias_ch, bias_valid
    );
endinterface

// File: rtl/bias_fetch_scheduler.sv
// Fetches channel biases 0..N-1 from a shared single-port BRAM into a credit-limited prefetch FIFO,
// yielding the port to loader writes, and pulses layer_done once the last bias has been consumed.
module bias_fetch_scheduler #(
    parameter int BRAM_DATA_WIDTH    = 32,
    parameter int BRAM_ADDRESS_WIDTH = 9,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] ch_size,
    output logic        busy,
    output logic        layer_done,
    bias_fetch_scheduler_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state_q;
    logic [11:0] n_q, issued_q, delivered_q;
    logic        v1_q, v2_q;
    logic [11:0] ch1_q, ch2_q;
    logic        layer_done_q;

    logic [BRAM_DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [11:0]                fifo_ch_q   [FIFO_DEPTH];
    logic [CW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [CW:0]                cnt_q;

    logic          rd_issue;
    logic          push, pop;
    logic [CW+1:0] used_w;

    // Credits: every read in the pipe already owns a FIFO slot.
    assign used_w   = {1'b0, cnt_q} + (CW+2)'(v1_q) + (CW+2)'(v2_q);
    assign rd_issue = (state_q == RUN) && !bus.wr_req && (issued_q < n_q)
                      && (used_w < (CW+2)'(FIFO_DEPTH));
    assign push     = v2_q;
    assign pop      = (cnt_q != '0) && bus.bias_ready;

    assign bus.wr_grant   = bus.wr_req;
    assign bus.bram_en    = bus.wr_req | rd_issue;
    assign bus.bram_we    = bus.wr_req;
    assign bus.bram_addr  = bus.wr_req ? bus.wr_addr : issued_q[BRAM_ADDRESS_WIDTH-1:0];
    assign bus.bram_wdata = bus.wr_data;

    assign bus.bias_valid = (cnt_q != '0);
    assign bus.bias_out   = bus.bias_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign bus.bias_ch    = bus.bias_valid ? fifo_ch_q[rd_ptr_q] : '0;
    assign busy           = (state_q != IDLE);
    assign layer_done     = layer_done_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= bus.bram_rdata;
            fifo_ch_q[wr_ptr_q]   <= ch2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            n_q          <= '0;
            issued_q     <= '0;
            delivered_q  <= '0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            ch1_q        <= '0;
            ch2_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            layer_done_q <= 1'b0;
        end else begin
            layer_done_q <= 1'b0;
            v1_q         <= rd_issue;
            v2_q         <= v1_q;
            ch2_q        <= ch1_q;
            if (rd_issue) begin
                ch1_q    <= issued_q;
                issued_q <= issued_q + 12'd1;
            end
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + 1'b1;
                delivered_q <= delivered_q + 12'd1;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase

            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (ch_size != 12'd0) begin
                            n_q         <= ch_size;
                            issued_q    <= '0;
                            delivered_q <= '0;
                            state_q     <= RUN;
                        end else begin
                            layer_done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issued_q == n_q) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (delivered_q == n_q) begin
                        layer_done_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
